data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 22 ++
 rtl/cache_data_array.sv | 31 +++
 rtl/data_cache.sv | 157 +++++++++++++++
 tb/tb_data_cache.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package data_cache_pkg;

    localparam int LINES_DEF = 64;
    localparam int ADDR_W    = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_t;

    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_w(input int lines);
        return ADDR_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/cache_data_array.sv
// Line storage: one 32-bit word per line, byte-writable, registered read port.
module cache_data_array #(
    parameter int LINES = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [3:0]       i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [31:0]      i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [LINES];
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-line data cache; write-through, no write-allocate.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int LINES = LINES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         dcache_addr,
    input  logic                dcache_re,
    input  logic [3:0]          dcache_we,
    input  logic [31:0]         dcache_din,
    output logic [31:0]         dcache_dout,
    output logic                stall,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [31:0]         mem_req_data,
    output logic [3:0]          mem_req_mask,
    input  logic                mem_resp_valid,
    input  logic [31:0]         mem_resp_data
);

    localparam int IDX_W = idx_w(LINES);
    localparam int TAG_W = tag_w(LINES);

    state_t              r_state;
    logic                r_req_valid;
    logic                r_req_rw;
    logic [ADDR_W-1:0]   r_req_addr;
    logic [31:0]         r_req_data;
    logic [3:0]          r_req_mask;
    logic [31:0]         r_dout;
    logic                r_sel_arr;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tags [LINES];

    logic [ADDR_W-1:0]   w_addr;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_fill_idx;
    logic                w_hit;
    logic                w_idle;
    logic                w_wr;
    logic                w_rd;
    logic                w_rd_hit;
    logic                w_fill;
    logic [3:0]          w_arr_we;
    logic [IDX_W-1:0]    w_arr_waddr;
    logic [31:0]         w_arr_wdata;
    logic [31:0]         w_arr_rdata;
    logic                w_unused;

    assign w_unused   = &{1'b0, dcache_addr[1:0]};
    assign w_addr     = dcache_addr[31:2];
    assign w_idx      = w_addr[IDX_W-1:0];
    assign w_tag      = w_addr[ADDR_W-1:IDX_W];
    assign w_fill_idx = r_req_addr[IDX_W-1:0];
    assign w_hit      = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    assign w_idle     = (r_state == IDLE);
    assign w_wr       = w_idle && (|dcache_we);
    assign w_rd       = w_idle && !(|dcache_we) && dcache_re;
    assign w_rd_hit   = w_rd && w_hit;
    assign w_fill     = (r_state == RD_WAIT) && mem_resp_valid;

    // Fill and write-hit never coincide: they live in different states.
    assign w_arr_we    = w_fill ? 4'hF :
                         (w_wr && w_hit) ? dcache_we : 4'h0;
    assign w_arr_waddr = w_fill ? w_fill_idx : w_idx;
    assign w_arr_wdata = w_fill ? mem_resp_data : dcache_din;

    cache_data_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_re    (w_rd_hit),
        .i_raddr (w_idx),
        .o_rdata (w_arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tags[w_fill_idx] <= r_req_addr[ADDR_W-1:IDX_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_req_valid <= 1'b0;
            r_req_rw    <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_mask  <= '0;
            r_dout      <= '0;
            r_sel_arr   <= 1'b0;
            r_valid     <= '0;
        end else begin
            // A hit's array output is shown for one cycle, then latched.
            if (r_sel_arr) begin
                r_dout <= w_arr_rdata;
            end
            r_sel_arr <= w_rd_hit;
            unique case (r_state)
                IDLE: begin
                    if (w_wr) begin
                        r_state     <= WR_REQ;
                        r_req_valid <= 1'b1;
                        r_req_rw    <= 1'b1;
                        r_req_addr  <= w_addr;
                        r_req_data  <= dcache_din;
                        r_req_mask  <= dcache_we;
                    end else if (w_rd && !w_hit) begin
                        r_state     <= RD_REQ;
                        r_req_valid <= 1'b1;
                        r_req_rw    <= 1'b0;
                        r_req_addr  <= w_addr;
                        r_req_mask  <= 4'hF;
                    end
                end
                RD_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (mem_resp_valid) begin
                        r_dout              <= mem_resp_data;
                        r_valid[w_fill_idx] <= 1'b1;
                        r_state             <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

    assign stall         = (r_state != IDLE);
    assign dcache_dout   = r_sel_arr ? w_arr_rdata : r_dout;
    assign mem_req_valid = r_req_valid;
    assign mem_req_rw    = r_req_rw;
    assign mem_req_addr  = r_req_addr;
    assign mem_req_data  = r_req_data;
    assign mem_req_mask  = r_req_mask;

endmodule

// File: tb/tb_data_cache.sv
// Directed and randomized checks of data_cache against a line/memory model.
module tb_data_cache;

    localparam int LINES = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [29:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    data_cache #(.LINES(LINES)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .stall          (stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rw     (mem_req_rw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: backing memory plus per-line valid/tag/data.
    logic [31:0] mem [bit [29:0]];
    bit          m_valid [LINES];
    bit [23:0]   m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] exp_dout;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_touch(input bit [29:0] wa);
        if (!mem.exists(wa)) mem[wa] = $urandom;
    endtask

    // Caller is at a negedge with the cache idle; returns at the negedge of
    // the first idle cycle after completion with re/we dropped.
    task automatic access(input logic [31:0] addr, input logic re,
                          input logic [3:0] we, input logic [31:0] din,
                          input int dly, input int rdly);
        bit [29:0]   wa;
        int          idx;
        bit [23:0]   tg;
        bit          is_wr;
        bit          is_rd;
        bit          hit;
        bit          done;
        int          exp_stall;
        int          stalls;
        int          w;
        int          r;
        logic [31:0] rd_word;
        wa    = addr[31:2];
        idx   = int'(wa % LINES);
        tg    = wa[29:6];
        is_wr = (we != 4'h0);
        is_rd = !is_wr && re;
        hit   = m_valid[idx] && (m_tag[idx] == tg);
        mem_touch(wa);
        rd_word   = mem[wa];
        exp_stall = is_wr ? dly + 1 : (is_rd && !hit) ? dly + rdly + 2 : 0;
        dcache_addr = addr;
        dcache_re   = re;
        dcache_we   = we;
        dcache_din  = din;
        stalls = 0;
        w      = 0;
        r      = 0;
        done   = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_data  = 32'h0;
            if (!stall) begin
                done = 1;
                break;
            end
            stalls++;
            if (mem_req_valid) begin
                chk("req_addr", {2'b0, mem_req_addr}, {2'b0, wa});
                chk("req_rw", {31'b0, mem_req_rw}, {31'b0, is_wr});
                if (is_wr) begin
                    chk("req_data", mem_req_data, din);
                    chk("req_mask", {28'b0, mem_req_mask}, {28'b0, we});
                end
                if (w == dly) begin
                    mem_req_ready = 1'b1;
                    if (is_rd) begin
                        mem_resp_valid = 1'b1;
                        mem_resp_data  = ~rd_word;
                    end
                end
                w++;
            end else begin
                if (r == rdly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rd_word;
                end
                r++;
            end
        end
        chk("timeout", {31'b0, done}, 32'd1);
        chk("stall_cycles", stalls, exp_stall);
        chk("mem_valid_idle", {31'b0, mem_req_valid}, 32'd0);
        if (is_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem[wa][8*b +: 8] = din[8*b +: 8];
                    if (hit) m_data[idx][8*b +: 8] = din[8*b +: 8];
                end
            end
        end else if (is_rd) begin
            if (!hit) begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
                m_data[idx]  = rd_word;
            end
            exp_dout = m_data[idx];
        end
        chk("dout", dcache_dout, exp_dout);
        dcache_re = 1'b0;
        dcache_we = 4'h0;
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        int          k;
        reset          = 1'b1;
        dcache_addr    = 32'h0;
        dcache_re      = 1'b0;
        dcache_we      = 4'h0;
        dcache_din     = 32'h0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = 32'h0;
        exp_dout       = 32'h0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        mem[30'h40] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_dout", dcache_dout, 32'h0);
        reset = 1'b0;

        access(32'h100, 1'b1, 4'h0, 32'h0, 0, 2);
        chk("cold_read", dcache_dout, 32'hDEADBEEF);
        access(32'h100, 1'b1, 4'h0, 32'h0, 0, 0);
        chk("hit_read", dcache_dout, 32'hDEADBEEF);
        access(32'h100, 1'b0, 4'b0011, 32'h0000CAFE, 5, 0);
        access(32'h100, 1'b1, 4'h0, 32'h0, 0, 0);
        chk("merged_read", dcache_dout, 32'hDEADCAFE);
        access(32'h500, 1'b1, 4'h0, 32'h0, 1, 1);
        access(32'h100, 1'b1, 4'h0, 32'h0, 0, 1);
        chk("refill_read", dcache_dout, 32'hDEADCAFE);
        access(32'h100, 1'b0, 4'h0, 32'h0, 0, 0);
        access(32'h104, 1'b1, 4'hF, 32'h01234567, 2, 0);
        access(32'h100, 1'b1, 4'hF, 32'h89ABCDEF, 0, 0);
        access(32'h100, 1'b1, 4'h0, 32'h0, 0, 0);
        chk("wr_prec_read", dcache_dout, 32'h89ABCDEF);

        // Reset while waiting for a read response.
        dcache_addr = 32'h500;
        dcache_re   = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rdwait_stall", {31'b0, stall}, 32'd1);
        #2 reset = 1'b1;
        dcache_re = 1'b0;
        #1;
        chk("async_stall", {31'b0, stall}, 32'd0);
        chk("async_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("async_dout", dcache_dout, 32'h0);
        @(negedge clk);
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h12345678;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        chk("late_resp_stall", {31'b0, stall}, 32'd0);
        chk("late_resp_dout", dcache_dout, 32'h0);
        for (int i = 0; i < LINES; i++) m_valid[i] = 0;
        exp_dout = 32'h0;
        access(32'h500, 1'b1, 4'h0, 32'h0, 1, 0);

        for (int it = 0; it < 80; it++) begin
            a = ((32'($urandom_range(0, 3)) * 32'd64
                 + 32'($urandom_range(0, 7))) << 2)
                | 32'($urandom_range(0, 3));
            k = $urandom_range(0, 9);
            m = 4'($urandom_range(1, 15));
            if (k < 6) begin
                access(a, 1'b1, 4'h0, $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (k < 9) begin
                access(a, k[0], m, $urandom, $urandom_range(0, 3), 0);
            end else begin
                access(a, 1'b0, 4'h0, $urandom, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
